button_press_latch: RTL and testbench
=====================================

Name: button_press_latch

Overview:
- Upstream conditioning stage for the LED shift register. Turns the raw, bouncing pushbutton into a clean debounced level and a single press event.
- Holds each press as a pending flag until the shift register's next shift strobe consumes it, so no press is lost or duplicated regardless of strobe rate.
- Flags overrun when a second press arrives before the first was consumed.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz); a value of 0 is treated as 1.
- SYNC_STAGES, 2, flip-flops in the input synchronizer; legal range is 2 or more.
- CNT_W, 28, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- rst_in  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous pushbutton, active high.
- tick_in  input  1  one-cycle shift strobe from the shift register (its 1 Hz rising-edge detect).
- overrun_clr_in  input  1  clears overrun_out.
- btn_level_out  output  1  debounced button level.
- press_pulse_out  output  1  one-cycle pulse on each accepted press.
- pressed_out  output  1  pending-press flag, sampled by the shift register on tick_in.
- overrun_out  output  1  sticky flag: a press was lost.

Behaviour:
- Reset (rst_in=1 at a rising edge): synchronizer chain, counter, btn_level_out, press_pulse_out, pressed_out and overrun_out all become 0; FSM goes to IDLE_LOW. Reset overrides every other input, including mid-debounce and while a press is pending.
- Synchronizer: btn_in passes through SYNC_STAGES flops; sync_out is the last stage. No other logic touches btn_in.
- Debounce FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: sync_out=1 -> WAIT_HIGH, counter=1.
  - WAIT_HIGH: sync_out=0 -> IDLE_LOW (glitch rejected, no output change). sync_out=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE_HIGH. Otherwise counter increments.
  - IDLE_HIGH and WAIT_LOW mirror the above for the falling direction; no event is generated on release.
  - Net effect: btn_level_out rises on the edge that sees the DEBOUNCE_CYCLES-th consecutive sync_out=1 sample. Latency from the first edge sampling btn_in=1 is SYNC_STAGES+DEBOUNCE_CYCLES edges, that edge included.
  - With DEBOUNCE_CYCLES=1, the transition happens directly from IDLE_LOW/IDLE_HIGH.
- Press event: press_pulse_out=1 for exactly one cycle, registered on the same edge btn_level_out rises.
- pressed_out, next-state priority:
  - press event -> 1;
  - else tick_in -> 0;
  - else hold.
  - Downstream samples the pre-edge value during the tick_in cycle. When press and tick coincide, the old press is consumed and the new one stays pending (pressed_out remains 1).
- overrun_out:
  - Set when a press event occurs while pressed_out=1 and tick_in=0.
  - Else cleared by overrun_clr_in.
  - Set wins over a simultaneous clear. Sticky otherwise.
- Button held through reset release: FSM starts at IDLE_LOW and reports a normal press after the debounce latency.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and reloads on every state change.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_in 0->1 first sampled at edge 10, held 30 cycles -> btn_level_out, press_pulse_out and pressed_out go 1 after edge 15; press_pulse_out returns to 0 after edge 16; release produces no pulse, and btn_level_out falls 6 edges after btn_in=0 is first sampled.
- Glitch rejection: btn_in high for 3 cycles, then bounce patterns 1-0-1-0 -> btn_level_out, press_pulse_out and pressed_out stay 0.
- Consumption: pressed_out=1, tick_in pulsed at edge 40 -> pressed_out reads 1 during the tick cycle and 0 after edge 40; a further tick_in leaves it at 0.
- Coincidence: press event and tick_in on the same edge with pressed_out=1 -> pressed_out stays 1 and overrun_out stays 0; the next tick_in clears pressed_out.
- Overrun: two accepted presses with no tick_in -> overrun_out=1 after the second press; overrun_clr_in pulse -> 0. Overrun condition and overrun_clr_in on the same edge -> overrun_out=1.
- Reset mid-operation: rst_in at debounce count 2 with pressed_out=1 and overrun_out=1 -> all outputs 0 the next cycle. btn_in still held -> press reported 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/button_press_latch.sv
// Pushbutton conditioning: synchronizer, debounce FSM, one-shot press event,
// pending-press flag consumed by the shift strobe, and a sticky overrun flag.
module button_press_latch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 28
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  input  logic tick_in,
  input  logic overrun_clr_in,
  output logic btn_level_out,
  output logic press_pulse_out,
  output logic pressed_out,
  output logic overrun_out
);

  localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] DB_M1 = CNT_W'(DB - 1);
  localparam bit DB_ONE = (DB == 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_out;
  logic                   w_press_evt;
  logic                   w_release_evt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Level changes are accepted on the edge that sees the DB-th stable sample.
  always_comb begin
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    case (r_state)
      IDLE_LOW:  w_press_evt   = w_sync_out && DB_ONE;
      WAIT_HIGH: w_press_evt   = w_sync_out && (r_cnt == DB_M1);
      IDLE_HIGH: w_release_evt = !w_sync_out && DB_ONE;
      WAIT_LOW:  w_release_evt = !w_sync_out && (r_cnt == DB_M1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync          <= '0;
      r_state         <= IDLE_LOW;
      r_cnt           <= '0;
      btn_level_out   <= 1'b0;
      press_pulse_out <= 1'b0;
      pressed_out     <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      r_sync          <= {r_sync[SYNC_STAGES-2:0], btn_in};
      press_pulse_out <= w_press_evt;

      case (r_state)
        IDLE_LOW: begin
          if (w_press_evt) begin
            r_state       <= IDLE_HIGH;
            btn_level_out <= 1'b1;
          end else if (w_sync_out) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!w_sync_out) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (w_press_evt) begin
            r_state       <= IDLE_HIGH;
            r_cnt         <= '0;
            btn_level_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (w_release_evt) begin
            r_state       <= IDLE_LOW;
            btn_level_out <= 1'b0;
          end else if (!w_sync_out) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (w_sync_out) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (w_release_evt) begin
            r_state       <= IDLE_LOW;
            r_cnt         <= '0;
            btn_level_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
        end
      endcase

      // A press coinciding with a tick replaces the consumed one.
      if (w_press_evt)  pressed_out <= 1'b1;
      else if (tick_in) pressed_out <= 1'b0;

      if (w_press_evt && pressed_out && !tick_in) overrun_out <= 1'b1;
      else if (overrun_clr_in)                    overrun_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_press_latch.sv
// Cycle-accurate vector bench for button_press_latch with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2. Expected outputs are {level, pulse, pressed, overrun}.
module tb_button_press_latch;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic btn_in = 1'b0;
  logic tick_in = 1'b0;
  logic overrun_clr_in = 1'b0;
  logic btn_level_out, press_pulse_out, pressed_out, overrun_out;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    string      name;
    logic       rst, btn, tick, clr;
    int         n;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  button_press_latch #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2),
    .CNT_W(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .btn_in(btn_in),
    .tick_in(tick_in),
    .overrun_clr_in(overrun_clr_in),
    .btn_level_out(btn_level_out),
    .press_pulse_out(press_pulse_out),
    .pressed_out(pressed_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void add(input string name, input logic rst, btn, tick, clr,
                              input int n, input logic [3:0] e);
    vec_t v;
    v.name = name; v.rst = rst; v.btn = btn; v.tick = tick; v.clr = clr;
    v.n = n; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic run(input string name, input logic rst, btn, tick, clr,
                     input int n, input logic [3:0] e);
    logic [3:0] got, want;
    for (int k = 0; k < n; k++) begin
      rst_in = rst; btn_in = btn; tick_in = tick; overrun_clr_in = clr;
      exp_q.push_back(e);
      @(posedge clk_in);
      #1;
      got  = {btn_level_out, press_pulse_out, pressed_out, overrun_out};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cycle %0d: got lvl/pls/prs/ovr=%b expected %b", name, k, got, want);
      end
    end
  endtask

  initial begin
    //  name          rst btn tick clr  n  exp
    add("reset",        1, 0, 0, 0, 2, 4'b0000);
    add("idle",         0, 0, 0, 0, 3, 4'b0000);
    add("press_wait",   0, 1, 0, 0, 5, 4'b0000);
    add("press_edge",   0, 1, 0, 0, 1, 4'b1110);
    add("press_hold",   0, 1, 0, 0, 10, 4'b1010);
    add("rel_wait",     0, 0, 0, 0, 5, 4'b1010);
    add("rel_edge",     0, 0, 0, 0, 1, 4'b0010);
    add("rel_hold",     0, 0, 0, 0, 3, 4'b0010);
    add("tick_consume", 0, 0, 1, 0, 1, 4'b0000);
    add("tick_again",   0, 0, 1, 0, 1, 4'b0000);
    add("tick_idle",    0, 0, 0, 0, 2, 4'b0000);
    add("glitch_hi3",   0, 1, 0, 0, 3, 4'b0000);
    add("glitch_lo",    0, 0, 0, 0, 1, 4'b0000);
    add("glitch_hi",    0, 1, 0, 0, 1, 4'b0000);
    add("glitch_lo",    0, 0, 0, 0, 1, 4'b0000);
    add("glitch_hi",    0, 1, 0, 0, 1, 4'b0000);
    add("glitch_tail",  0, 0, 0, 0, 4, 4'b0000);
    add("ovr_p1_wait",  0, 1, 0, 0, 5, 4'b0000);
    add("ovr_p1_edge",  0, 1, 0, 0, 1, 4'b1110);
    add("ovr_p1_hold",  0, 1, 0, 0, 3, 4'b1010);
    add("ovr_r_wait",   0, 0, 0, 0, 5, 4'b1010);
    add("ovr_r_edge",   0, 0, 0, 0, 1, 4'b0010);
    add("ovr_r_hold",   0, 0, 0, 0, 2, 4'b0010);
    add("ovr_p2_wait",  0, 1, 0, 0, 5, 4'b0010);
    add("ovr_p2_edge",  0, 1, 0, 0, 1, 4'b1111);
    add("ovr_p2_hold",  0, 1, 0, 0, 3, 4'b1011);
    add("ovr_clear",    0, 1, 0, 1, 1, 4'b1010);
    add("ovr_cleared",  0, 1, 0, 0, 2, 4'b1010);

    foreach (vecs[i])
      run(vecs[i].name, vecs[i].rst, vecs[i].btn, vecs[i].tick, vecs[i].clr,
          vecs[i].n, vecs[i].exp);

    // Press event lands on the same edge as a tick while a press is pending.
    run("coin_r_wait",  0, 0, 0, 0, 5, 4'b1010);
    run("coin_r_edge",  0, 0, 0, 0, 1, 4'b0010);
    run("coin_r_hold",  0, 0, 0, 0, 2, 4'b0010);
    run("coin_p_wait",  0, 1, 0, 0, 5, 4'b0010);
    run("coin_p_tick",  0, 1, 1, 0, 1, 4'b1110);
    run("coin_p_hold",  0, 1, 0, 0, 2, 4'b1010);
    run("coin_tick2",   0, 1, 1, 0, 1, 4'b1000);
    run("coin_after",   0, 1, 0, 0, 2, 4'b1000);

    // Overrun set and clear requested on the same edge: set wins.
    run("setclr_r_wait", 0, 0, 0, 0, 5, 4'b1000);
    run("setclr_r_edge", 0, 0, 0, 0, 1, 4'b0000);
    run("setclr_r_hold", 0, 0, 0, 0, 2, 4'b0000);
    run("setclr_p1_wait", 0, 1, 0, 0, 5, 4'b0000);
    run("setclr_p1_edge", 0, 1, 0, 0, 1, 4'b1110);
    run("setclr_p1_hold", 0, 1, 0, 0, 2, 4'b1010);
    run("setclr_r2_wait", 0, 0, 0, 0, 5, 4'b1010);
    run("setclr_r2_edge", 0, 0, 0, 0, 1, 4'b0010);
    run("setclr_r2_hold", 0, 0, 0, 0, 2, 4'b0010);
    run("setclr_p2_wait", 0, 1, 0, 0, 5, 4'b0010);
    run("setclr_p2_edge", 0, 1, 0, 1, 1, 4'b1111);
    run("setclr_p2_hold", 0, 1, 0, 0, 2, 4'b1011);

    // Reset mid-debounce with a pending press and overrun, button kept held.
    run("rst_r_wait",   0, 0, 0, 0, 5, 4'b1011);
    run("rst_r_edge",   0, 0, 0, 0, 1, 4'b0011);
    run("rst_r_hold",   0, 0, 0, 0, 2, 4'b0011);
    run("rst_cnt2",     0, 1, 0, 0, 4, 4'b0011);
    run("rst_apply",    1, 1, 0, 0, 1, 4'b0000);
    run("rst_held_wait", 0, 1, 0, 0, 5, 4'b0000);
    run("rst_held_edge", 0, 1, 0, 0, 1, 4'b1110);
    run("rst_held_hold", 0, 1, 0, 0, 2, 4'b1010);
    run("rst_tick",     0, 1, 1, 0, 1, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
